// File: rtl/fp_mult_pkg.sv
// Shared types and helpers for the fp_mult_top wrapper: rounding modes,
// status bit positions, NaN detection and the result record.
package fp_mult_pkg;

    localparam int unsigned FP_W = 32;
    localparam int unsigned ST_W = 8;

    typedef enum logic [2:0] {
        RND_NEAREST_EVEN = 3'd0,
        RND_TO_ZERO      = 3'd1,
        RND_TO_POS_INF   = 3'd2,
        RND_TO_NEG_INF   = 3'd3,
        RND_NEAREST_UP   = 3'd4,
        RND_AWAY_ZERO    = 3'd5
    } round_values;

    localparam int unsigned ST_ZERO     = 0;
    localparam int unsigned ST_INF      = 1;
    localparam int unsigned ST_NAN      = 2;
    localparam int unsigned ST_TINY     = 3;
    localparam int unsigned ST_HUGE     = 4;
    localparam int unsigned ST_INEXACT  = 5;
    localparam int unsigned ST_HUGE_INT = 6;
    localparam int unsigned ST_INVALID  = 7;

    typedef struct packed {
        logic [FP_W-1:0] z;
        logic [ST_W-1:0] status;
        logic            mismatch;
    } result_t;

    function automatic logic is_nan(input logic [FP_W-1:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// First-word-fall-through circular FIFO for multiplier results; the head
// entry is presented on dout_o (zero while empty).
module fp_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 41
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_i && !pop_i)      count_q <= count_q + CW'(1);
            else if (!push_i && pop_i) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && (count_q == CW'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_i && (count_q == '0)));

endmodule

// File: rtl/fp_mult_issue_ctrl.sv
// Streaming issue/retire controller around the registered fp_mult_top:
// credit-based intake, fixed-latency tracking, result FIFO and statistics.
module fp_mult_issue_ctrl
    import fp_mult_pkg::*;
#(
    parameter int unsigned MULT_LAT  = 2,
    parameter int unsigned OUT_DEPTH = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [FP_W-1:0]     in_a,
    input  logic [FP_W-1:0]     in_b,
    output logic [FP_W-1:0]     mult_a,
    output logic [FP_W-1:0]     mult_b,
    input  logic [FP_W-1:0]     mult_z,
    input  logic [ST_W-1:0]     mult_status,
    input  logic [FP_W-1:0]     mult_zref,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [FP_W-1:0]     out_z,
    output logic [ST_W-1:0]     out_status,
    output logic                out_mismatch,
    output logic [ST_W-1:0]     sticky_status,
    output logic [CNT_W-1:0]    op_count,
    output logic [CNT_W-1:0]    mismatch_count,
    input  logic                clear
);

    localparam int unsigned CW = $clog2(OUT_DEPTH) + 1;
    localparam int unsigned TW = $clog2(OUT_DEPTH + MULT_LAT + 2) + 1;
    localparam int unsigned RW = $bits(result_t);

    logic                accept;
    logic                pop;
    logic                capture;
    logic                ready_en_q;
    logic                issue_q;
    logic [MULT_LAT-1:0] vld_pipe_q, vld_pipe_d;
    logic [FP_W-1:0]     mult_a_q, mult_b_q;
    logic [TW-1:0]       occupancy;
    logic [CW-1:0]       fifo_count;
    result_t             cap_rec, head_rec;
    logic [ST_W-1:0]     sticky_q, sticky_d;
    logic [CNT_W-1:0]    op_cnt_q, op_cnt_d;
    logic [CNT_W-1:0]    mm_cnt_q, mm_cnt_d;

    // issue_q marks the cycle mult_a/mult_b carry a fresh pair; the pipe then
    // follows that pair through the multiplier so capture lands MULT_LAT+1
    // cycles after accept.
    always_comb begin
        occupancy = TW'(fifo_count) + TW'(issue_q);
        for (int i = 0; i < int'(MULT_LAT); i++) begin
            occupancy = occupancy + TW'(vld_pipe_q[i]);
        end
        pop       = out_valid & out_ready;
        occupancy = occupancy - TW'(pop);
        in_ready  = ready_en_q && (occupancy < TW'(OUT_DEPTH));
        accept    = in_valid & in_ready;
    end

    always_comb begin
        vld_pipe_d    = '0;
        vld_pipe_d[0] = issue_q;
        for (int i = 1; i < int'(MULT_LAT); i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en_q <= 1'b0;
            issue_q    <= 1'b0;
            vld_pipe_q <= '0;
            mult_a_q   <= '0;
            mult_b_q   <= '0;
        end else begin
            ready_en_q <= 1'b1;
            issue_q    <= accept;
            vld_pipe_q <= vld_pipe_d;
            if (accept) begin
                mult_a_q <= in_a;
                mult_b_q <= in_b;
            end
        end
    end

    assign mult_a  = mult_a_q;
    assign mult_b  = mult_b_q;
    assign capture = vld_pipe_q[MULT_LAT-1];

    // Two NaNs with different payloads still count as agreement.
    always_comb begin
        cap_rec.z        = mult_z;
        cap_rec.status   = mult_status;
        cap_rec.mismatch = (mult_z != mult_zref) && !(is_nan(mult_z) && is_nan(mult_zref));
    end

    fp_result_fifo #(
        .DEPTH (OUT_DEPTH),
        .W     (RW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (capture),
        .din_i   (cap_rec),
        .pop_i   (pop),
        .dout_o  (head_rec),
        .count_o (fifo_count)
    );

    assign out_valid    = (fifo_count != '0);
    assign out_z        = head_rec.z;
    assign out_status   = head_rec.status;
    assign out_mismatch = head_rec.mismatch;

    // Statistics on retire; clear wins, counters saturate.
    always_comb begin
        sticky_d = sticky_q;
        op_cnt_d = op_cnt_q;
        mm_cnt_d = mm_cnt_q;
        if (clear) begin
            sticky_d = '0;
            op_cnt_d = '0;
            mm_cnt_d = '0;
        end else if (pop) begin
            sticky_d = sticky_q | out_status;
            if (op_cnt_q != '1) op_cnt_d = op_cnt_q + CNT_W'(1);
            if (out_mismatch && (mm_cnt_q != '1)) mm_cnt_d = mm_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_q <= '0;
            op_cnt_q <= '0;
            mm_cnt_q <= '0;
        end else begin
            sticky_q <= sticky_d;
            op_cnt_q <= op_cnt_d;
            mm_cnt_q <= mm_cnt_d;
        end
    end

    assign sticky_status  = sticky_q;
    assign op_count       = op_cnt_q;
    assign mismatch_count = mm_cnt_q;

endmodule

// File: tb/tb_fp_mult_issue_ctrl.sv
// Scoreboard bench for fp_mult_issue_ctrl with a table-driven two-stage
// multiplier stand-in answering the directed operand pairs.
module tb_fp_mult_issue_ctrl;
    import fp_mult_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic [7:0]  st;
        logic [31:0] zref;
        logic        mm;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] mult_a, mult_b;
    logic [31:0] mult_z, mult_zref;
    logic [7:0]  mult_status;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_z;
    logic [7:0]  out_status;
    logic        out_mismatch;
    logic [7:0]  sticky_status;
    logic [15:0] op_count;
    logic [15:0] mismatch_count;
    logic        clear = 1'b0;

    vec_t tab [16];
    vec_t sb [$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fp_mult_issue_ctrl #(.MULT_LAT(2), .OUT_DEPTH(4), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .mult_a         (mult_a),
        .mult_b         (mult_b),
        .mult_z         (mult_z),
        .mult_status    (mult_status),
        .mult_zref      (mult_zref),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_z          (out_z),
        .out_status     (out_status),
        .out_mismatch   (out_mismatch),
        .sticky_status  (sticky_status),
        .op_count       (op_count),
        .mismatch_count (mismatch_count),
        .clear          (clear)
    );

    // Two-register multiplier stand-in: answers from the vector table.
    logic [31:0] s1_z, s1_zref;
    logic [7:0]  s1_st;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_z <= '0; s1_zref <= '0; s1_st <= '0;
            mult_z <= '0; mult_zref <= '0; mult_status <= '0;
        end else begin
            s1_z <= '0; s1_zref <= '0; s1_st <= '0;
            for (int i = 0; i < 16; i++) begin
                if (tab[i].a == mult_a && tab[i].b == mult_b) begin
                    s1_z <= tab[i].z; s1_zref <= tab[i].zref; s1_st <= tab[i].st;
                end
            end
            mult_z <= s1_z; mult_zref <= s1_zref; mult_status <= s1_st;
        end
    end

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z,
                                input logic [7:0] st, input logic [31:0] zref, input logic mm);
        vec_t v;
        v.a = a; v.b = b; v.z = z; v.st = st; v.zref = zref; v.mm = mm;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        vec_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", out_z, 32'hDEAD_BEEF);
                end else begin
                    e = sb.pop_front();
                    chk("out_z", out_z, e.z);
                    chk("out_status", 32'(out_status), 32'(e.st));
                    chk("out_mismatch", 32'(out_mismatch), 32'(e.mm));
                end
            end
        end
    endtask

    task automatic issue(input int idx, output int stalls);
        bit done = 0;
        in_valid = 1'b1;
        in_a     = tab[idx].a;
        in_b     = tab[idx].b;
        stalls   = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                sb.push_back(tab[idx]);
                #1;
                done = 1;
            end else begin
                stalls++;
            end
        end
        if (!done) chk("issue_timeout", 32'(stalls), 32'(0));
    endtask

    task automatic drain();
        bit done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk);
            if (sb.size() == 0) done = 1;
        end
        if (!done) chk("drain_timeout", 32'(sb.size()), 32'(0));
        #1;
    endtask

    initial begin
        int st;
        int lat;
        int seen;
        tab[0]  = mk(32'h3F800000, 32'h40000000, 32'h40000000, 8'h00, 32'h40000000, 1'b0);
        tab[1]  = mk(32'h40400000, 32'h40400000, 32'h41100000, 8'h00, 32'h41100000, 1'b0);
        tab[2]  = mk(32'hBFC00000, 32'h40000000, 32'hC0400000, 8'h00, 32'hC0400000, 1'b0);
        tab[3]  = mk(32'h00000000, 32'h40A00000, 32'h00000000, 8'h01, 32'h00000000, 1'b0);
        tab[4]  = mk(32'h7F800000, 32'h00000000, 32'h7FC00000, 8'h84, 32'h7FFFFFFF, 1'b0);
        tab[5]  = mk(32'h3F800000, 32'h40400000, 32'h40400000, 8'h00, 32'h40400001, 1'b1);
        tab[6]  = mk(32'h40000000, 32'h3F800000, 32'h40000000, 8'h00, 32'h40000000, 1'b0);
        tab[7]  = mk(32'h40000000, 32'h40000000, 32'h40800000, 8'h00, 32'h40800000, 1'b0);
        tab[8]  = mk(32'h40000000, 32'h40400000, 32'h40C00000, 8'h00, 32'h40C00000, 1'b0);
        tab[9]  = mk(32'h40000000, 32'h40800000, 32'h41000000, 8'h00, 32'h41000000, 1'b0);
        tab[10] = mk(32'h40000000, 32'h40A00000, 32'h41200000, 8'h00, 32'h41200000, 1'b0);
        tab[11] = mk(32'h40000000, 32'h40C00000, 32'h41400000, 8'h00, 32'h41400000, 1'b0);
        tab[12] = mk(32'h40000000, 32'h40E00000, 32'h41600000, 8'h00, 32'h41600000, 1'b0);
        tab[13] = mk(32'h40000000, 32'h41000000, 32'h41800000, 8'h00, 32'h41800000, 1'b0);
        tab[14] = mk(32'h40000000, 32'h41100000, 32'h41900000, 8'h00, 32'h41900000, 1'b0);
        tab[15] = mk(32'h40000000, 32'h41200000, 32'h41A00000, 8'h00, 32'h41A00000, 1'b0);

        fork monitor(); join_none

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_z", out_z, 32'h0);
        chk("rst_mult_a", mult_a, 32'h0);
        chk("rst_op_count", 32'(op_count), 32'(0));
        chk("rst_sticky", 32'(sticky_status), 32'(0));
        rst = 1'b1;
        out_ready = 1'b1;

        // Single op: three-cycle latency.
        issue(0, st);
        in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (out_valid) lat = c;
        end
        chk("latency", 32'(lat), 32'(3));
        @(posedge clk); #1;
        chk("op_count_1", 32'(op_count), 32'(1));

        // Back-to-back stream, no stalls.
        seen = 0;
        issue(1, st); seen += st;
        issue(2, st); seen += st;
        issue(3, st); seen += st;
        in_valid = 1'b0;
        chk("stream_stalls", 32'(seen), 32'(0));
        drain();
        chk("op_count_4", 32'(op_count), 32'(4));

        // Inf x 0 then a normal op; NaN status stays sticky.
        issue(4, st);
        issue(0, st);
        in_valid = 1'b0;
        drain();
        chk("sticky_nan", 32'(sticky_status), 32'h85);
        chk("mm_count_nan", 32'(mismatch_count), 32'(0));
        chk("op_count_6", 32'(op_count), 32'(6));

        // Backpressure: four accepts, then in_ready holds low.
        out_ready = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            issue(6 + k, st); seen += st;
        end
        chk("bp_first4_stalls", 32'(seen), 32'(0));
        in_a = tab[10].a; in_b = tab[10].b;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (in_ready) seen++;
        end
        chk("bp_in_ready_low", 32'(seen), 32'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 4; k < 10; k++) issue(6 + k, st);
        in_valid = 1'b0;
        drain();
        chk("op_count_16", 32'(op_count), 32'(16));

        // Injected model disagreement, then clear.
        issue(5, st);
        in_valid = 1'b0;
        drain();
        chk("mm_count_1", 32'(mismatch_count), 32'(1));
        chk("op_count_17", 32'(op_count), 32'(17));
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr_op_count", 32'(op_count), 32'(0));
        chk("clr_mm_count", 32'(mismatch_count), 32'(0));
        chk("clr_sticky", 32'(sticky_status), 32'(0));

        // Reset with two ops in flight and two queued.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) issue(6 + k, st);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_queued", 32'(out_valid), 32'(1));
        #2;
        rst = 1'b0;
        #1;
        sb.delete();
        chk("async_out_valid", 32'(out_valid), 32'(0));
        chk("async_in_ready", 32'(in_ready), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("no_stale_result", 32'(seen), 32'(0));
        chk("post_rst_op_count", 32'(op_count), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
